imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side counterpart to the processor's 256x16 instruction memory read port.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Drives the instruction RAM write port, then checks a trailing XOR checksum byte.
- Holds the CPU in stall (cpu_hold) while a program is being loaded.

Parameters:
- ADDR_W, 8, instruction memory address width (256 words).
- DATA_W, 16, instruction word width. Fixed at 2 bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load. Honoured only in IDLE.
- base_addr  input  8  first write address. Sampled on an accepted start.
- word_count  input  9  number of words to load. Sampled on an accepted start.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can take a byte this cycle.
- wr_en  output  1  instruction RAM write strobe.
- wr_addr  output  8  instruction RAM write address.
- wr_data  output  16  instruction RAM write data.
- busy  output  1  load in progress.
- cpu_hold  output  1  stall request to the processor. Equal to busy.
- done  output  1  one-cycle pulse at end of load.
- err  output  1  checksum mismatch flag. Sticky until the next accepted start.

Behaviour:
- Reset, asynchronous and immediate:
  - State IDLE.
  - All outputs 0: in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err.
  - Internal count, address and checksum cleared.
- A byte is accepted only when in_valid && in_ready.
- in_ready is combinationally 1 only in states HI and LO.
- States and transitions:
  - IDLE:
    - On start, latch addr=base_addr, remaining=min(word_count,256), csum=0, clear err.
    - If remaining==0, go to FIN. Otherwise go to HI. busy=1 from the next cycle.
    - start in any other state is ignored.
  - HI: on accept, hold byte as word[15:8], csum^=byte, go to LO.
  - LO:
    - On accept, word[7:0]=byte, csum^=byte, go to WR.
  - WR, exactly one cycle:
    - wr_en=1, wr_addr=addr, wr_data=assembled word.
    - addr=addr+1, wrapping 255->0. remaining-=1.
    - If remaining becomes 0, go to CK. Otherwise go to HI.
  - CK:
    - in_ready=1. On accept, err=(byte!=csum), go to FIN.
    - The checksum byte is not XORed into csum.
  - FIN, one cycle: done=1, busy=0 on exit, go to IDLE. err remains valid.
- Latency:
  - A write occurs exactly 1 cycle after the low byte is accepted.
  - Minimum load of N words takes 3N+2 cycles after start, with in_valid held high.
- Throughput: at most one byte every cycle in HI/LO. WR inserts one bubble per word (in_ready=0).
- wr_en is 0 in every state except WR.
- wr_addr and wr_data hold their last values when wr_en=0.
- word_count values 257..511 saturate to 256.
- Address wrap is silent: loading 4 words at base 254 writes 254, 255, 0, 1.
- in_valid deasserted mid-word: stay in the current state indefinitely. No timeout.
- Reset mid-load:
  - Aborts at once; no further writes.
  - RAM contents already written are kept.
  - done is not pulsed.
- busy and cpu_hold are 1 in HI, LO, WR and CK. They are 0 in IDLE and FIN.
- Unloaded RAM locations are untouched; they keep their existing default NOP fill.

Test Plan:
- Basic load:
  - Stimulus: start with base=0, count=2, bytes 0x04,0x68,0x14,0x25, checksum 0x04^0x68^0x14^0x25=0x5D.
  - Required: writes {0:0x0468, 1:0x1425}, each 1 cycle after its low byte; done pulse; err=0; cpu_hold high from start+1 to FIN.
- Bad checksum:
  - Stimulus: same stream with checksum 0x5C.
  - Required: both writes still occur; err=1 after done; err clears on the next start.
- Wrap and backpressure:
  - Stimulus: base=255, count=2; in_valid toggles 1,0,0,1 between bytes.
  - Required: writes to addresses 255 then 0; no byte lost or duplicated; in_ready=0 during each WR cycle.
- Edge counts:
  - word_count=0: done 2 cycles after start; no wr_en; no bytes accepted.
  - word_count=300: exactly 256 writes, then the checksum byte.
- Reset and ignored start:
  - Stimulus: assert rst_n=0 after the first word's write; separately, pulse start mid-load.
  - Required (reset): all outputs 0 immediately; 1 write total; no done.
  - Required (mid-load start): ignored; base and count unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a program image into the 256x16 instruction RAM.
// Bytes arrive over a valid/ready handshake, are paired big-endian into
// 16-bit words and written one word per WR cycle. A trailing XOR checksum
// byte is compared against the running XOR of all payload bytes. The CPU
// is held in stall for the whole load.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Remaining-word counter is one bit wider than the address so that a
    // full 256-word image can be represented.
    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_WR   = 3'd3,
        S_CK   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [ADDR_W-1:0]   addr_reg;
    logic [CNT_W-1:0]    remaining_reg;
    logic [7:0]          csum_reg;
    logic [7:0]          hi_byte_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [DATA_W-1:0]   wr_data_reg;
    logic                err_reg;

    logic                accept;
    logic                start_ok;
    logic [CNT_W-1:0]    count_sat;

    // A start is only meaningful while idle; anywhere else it is dropped.
    assign start_ok  = start && (state_reg == S_IDLE);
    assign accept    = in_valid && in_ready;
    // Oversized requests clamp to the full memory depth.
    assign count_sat = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (count_sat == '0) ? S_FIN : S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_next = S_WR;
                end
            end
            S_WR: begin
                // Last word written: only the checksum byte is left.
                state_next = (remaining_reg == CNT_W'(1)) ? S_CK : S_HI;
            end
            S_CK: begin
                if (accept) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: all handshake/status strobes are pure functions of state.
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
            end
            S_HI, S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WR: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            S_CK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cpu_hold = busy;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign err      = err_reg;

    // Load parameters and word counter: latched on start, stepped per write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else if (start_ok) begin
            addr_reg      <= base_addr;
            remaining_reg <= count_sat;
        end else if (state_reg == S_WR) begin
            // Address wraps naturally at the top of memory.
            addr_reg      <= addr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
        end
    end

    // Running checksum over payload bytes and the held high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_reg    <= '0;
            hi_byte_reg <= '0;
        end else if (start_ok) begin
            csum_reg    <= '0;
        end else if (accept && (state_reg == S_HI)) begin
            hi_byte_reg <= in_data;
            csum_reg    <= csum_reg ^ in_data;
        end else if (accept && (state_reg == S_LO)) begin
            csum_reg    <= csum_reg ^ in_data;
        end
    end

    // Write port registers: loaded with the low byte so the write fires in
    // the following cycle, and held afterwards so the RAM port stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else if (accept && (state_reg == S_LO)) begin
            wr_addr_reg <= addr_reg;
            wr_data_reg <= {hi_byte_reg, in_data};
        end
    end

    // Checksum verdict: cleared by a new load, set by the trailing byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (start_ok) begin
            err_reg <= 1'b0;
        end else if (accept && (state_reg == S_CK)) begin
            err_reg <= (in_data != csum_reg);
        end
    end

`ifndef SYNTHESIS
    // The WR bubble must never coincide with a byte being taken.
    a_wr_bubble: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> !in_ready);

    // Done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);
`endif

endmodule
